trig_record_fifo: RTL and testbench
===================================

# trig_record_fifo

Buffers fired-trigger records (8-bit trigger mask plus 56-bit timestamp) produced by the trigger-decision stage in the `clk_adc` domain. It presents them to the slow-control readout as a stream of 32-bit words under a pop handshake. It replaces the fixed 8-entry `triggerFired`/`clockCounter` snapshot arrays with a proper FIFO that has full, empty and drop accounting. It sits directly downstream of the trigger-decision logic and upstream of the host register interface.

## Interface
Parameters:
- `DEPTH`, 16: record slots; power of two, 2..256.
- `ADDR_W`, `$clog2(DEPTH)`: pointer width; derived, do not override.

Ports:
- `clk_adc` input 1: sole clock; all logic on the rising edge.
- `nrst` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous flush of the FIFO, pointers and drop counter.
- `trig_valid` input 1: one-cycle strobe; a trigger record is presented.
- `trig_mask` input 8: bitmask of the triggers that fired.
- `trig_time` input 56: timestamp of the record.
- `rd_en` input 1: pop one 32-bit word.
- `rd_data` output 32: popped word.
- `rd_valid` output 1: `rd_data` holds a new word this cycle.
- `empty` output 1: no unread word available.
- `full` output 1: all `DEPTH` slots are occupied.
- `level` output `ADDR_W+1`: number of stored records, including a partially read record.
- `drop_count` output 16: records lost to overflow; saturating.

## Operation
- Record format, default build:
  - word0 = {`trig_mask`, `trig_time[55:32]`}
  - word1 = `trig_time[31:0]`
- Write:
  - `trig_valid` with `full`=0 stores {mask, time} at the write pointer and increments the pointer and `level`.
  - `trig_valid` with `full`=1 discards the record and increments `drop_count`, saturating at 16'hFFFF.
  - A record with `trig_mask`=0 is stored as-is; no filtering.
- Read:
  - A word-select counter `wsel` steps through WORD0 → WORD1 (→ WORD0 again) for each record.
  - `rd_en` with `empty`=0 outputs the selected word of the head record and advances `wsel`.
  - Popping the last word frees the slot: the read pointer increments, `level` decrements and `wsel` returns to 0.
- `rd_en` with `empty`=1 is ignored: `rd_valid`=0 and `rd_data` holds its previous value.
- Simultaneous write and last-word pop in one cycle:
  - If `full`, the write is accepted; the freed slot is reused and nothing is dropped.
  - `level` is unchanged.
- Pointers are `ADDR_W+1` bits; the MSB distinguishes full from empty, and pointers wrap modulo 2·`DEPTH`.
- `clear` (synchronous): pointers, `level`, `wsel` and `drop_count` go to 0. A `trig_valid` in the same cycle is discarded and not counted. `clear` has priority over read and write.
- Reset values: `rd_data`=0, `rd_valid`=0, `empty`=1, `full`=0, `level`=0, `drop_count`=0. Storage contents are not reset.

## Timing
- Write to visibility: `trig_valid` in cycle N → `empty`=0 and `level` updated in N+1.
- Read latency: `rd_en` in cycle N → `rd_data`/`rd_valid` in N+1; `rd_valid` is a one-cycle pulse per accepted pop.
- Back-to-back `rd_en` is allowed every cycle, giving one word per cycle.
- `full`, `empty` and `level` are registered and reflect all operations of the previous cycle.
- Reset asserted mid-read: all outputs return to reset values immediately. A partially read record is lost.

## Configuration
- `TRIGREC_SEQ_EN` defined:
  - Each record gains a leading header word, so the sequence is HEADER → WORD0 → WORD1.
  - Header = {16'hA55A, `drop_count[7:0]` at write time, 8-bit sequence number}.
  - The sequence number increments on every accepted write and wraps 255→0. It is reset by `nrst`/`clear`.
  - Storage width becomes 80 bits per slot.
- Not defined: two words per record, no sequence counter, 64-bit storage.

## Structure
- Shared package `trig_pkg`:
  - `trig_record_t` struct {mask, time; plus seq and drop snapshot under the macro}.
  - `TRIG_MASK_W`=8, `TRIG_TIME_W`=56, `TRIGREC_MAGIC`=16'hA55A.
  - Word-select enum `WSEL_HDR`, `WSEL_W0`, `WSEL_W1`.
- One sub-module `trig_record_ram`: simple dual-port RAM, `DEPTH`×record width, registered read, write-first not required.
- Pointer, flag, word-select and counter logic live in the top level.

## Test plan
- Reset, then write mask 8'h01, time 56'h00_1234_5678_9ABC, then pop twice → words 32'h0100_1234 and 32'h5678_9ABC; `empty`=1 afterwards.
- Write 16 records (`DEPTH`=16) → `full`=1, `level`=16. Write 3 more → `drop_count`=3. Drain all → records 0..15 in order.
- `full`, then `trig_valid` in the same cycle as the last-word pop of the head record → record accepted, `drop_count` unchanged, `level`=16.
- `rd_en` while empty → `rd_valid`=0, `rd_data` unchanged. Write then pop 10 000 records → pointers wrap and data matches.
- Pop word0 only, then pulse `clear` → `level`=0, `empty`=1. Next record starts at word0.
- With `TRIGREC_SEQ_EN`: write 257 records through pop-as-you-go → headers carry seq 0..255, 0, and magic 16'hA55A.

Source files
------------

// File: rtl/trig_pkg.sv
// trig_pkg: shared types and constants for the trigger record FIFO.
//   trig_record_t : one stored record (mask + timestamp, plus sequence number
//                   and drop snapshot when TRIGREC_SEQ_EN is defined)
//   wsel_e        : word-select within a record during readout
//   rec_word()    : formats one 32-bit readout word of a record
// Optional feature macro: TRIGREC_SEQ_EN (adds a leading header word).
package trig_pkg;

  localparam int          TRIG_MASK_W   = 8;
  localparam int          TRIG_TIME_W   = 56;
  localparam logic [15:0] TRIGREC_MAGIC = 16'hA55A;

  typedef enum logic [1:0] {
    WSEL_HDR = 2'd0,
    WSEL_W0  = 2'd1,
    WSEL_W1  = 2'd2
  } wsel_e;

`ifdef TRIGREC_SEQ_EN
  typedef struct packed {
    logic [7:0]             seq;
    logic [7:0]             drop;
    logic [TRIG_MASK_W-1:0] mask;
    logic [TRIG_TIME_W-1:0] timestamp;
  } trig_record_t;

  localparam wsel_e WSEL_FIRST = WSEL_HDR;
`else
  typedef struct packed {
    logic [TRIG_MASK_W-1:0] mask;
    logic [TRIG_TIME_W-1:0] timestamp;
  } trig_record_t;

  localparam wsel_e WSEL_FIRST = WSEL_W0;
`endif

  localparam int TRIG_REC_W = $bits(trig_record_t);

  // Select one 32-bit readout word of a record.
  function automatic logic [31:0] rec_word(input trig_record_t r, input wsel_e w);
    logic [31:0] word;
    case (w)
`ifdef TRIGREC_SEQ_EN
      WSEL_HDR: word = {TRIGREC_MAGIC, r.drop, r.seq};
`else
      WSEL_HDR: word = 32'h0000_0000;
`endif
      WSEL_W0:  word = {r.mask, r.timestamp[55:32]};
      WSEL_W1:  word = r.timestamp[31:0];
      default:  word = 32'h0000_0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/trig_record_ram.sv
// trig_record_ram: simple dual-port record storage, registered read.
//   clk     : clock          nrst    : async active-low reset (read register only)
//   wr_en   : write strobe   wr_addr : write slot   wr_data : record to store
//   rd_addr : read slot      rd_data : record read, one cycle after rd_addr
// Storage contents are not reset. A read and write to the same slot in one
// cycle returns the old contents; the caller forwards around that case.
module trig_record_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WIDTH  = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Read port mux.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trig_record_fifo.sv
// trig_record_fifo: buffers fired-trigger records and streams them out as
// 32-bit words under a pop handshake.
//   clk_adc, nrst              : clock, async active-low reset
//   clear                      : synchronous flush (pointers, level, wsel, drops)
//   trig_valid/mask/time       : incoming record strobe and payload
//   rd_en                      : pop one word; rd_data/rd_valid one cycle later
//   empty/full/level           : registered occupancy status
//   drop_count                 : saturating count of records lost to overflow
// Optional feature macro: TRIGREC_SEQ_EN (header word with magic, drop
// snapshot and sequence number ahead of each record).
module trig_record_fifo
  import trig_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_adc,
  input  logic              nrst,
  input  logic              clear,
  input  logic              trig_valid,
  input  logic [7:0]        trig_mask,
  input  logic [55:0]       trig_time,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic [15:0]       drop_count
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic            empty_q, empty_d, full_q, full_d;
  logic            rd_valid_q, rd_valid_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic [15:0]     drop_q, drop_d;
  wsel_e           wsel_q, wsel_d;
  logic            byp_q, byp_d;
  trig_record_t    byp_rec_q, byp_rec_d;
`ifdef TRIGREC_SEQ_EN
  logic [7:0]      seq_q, seq_d;
`endif

  logic                  pop, pop_last, wr_en;
  trig_record_t          wr_rec, head_rec;
  logic [TRIG_REC_W-1:0] ram_rd_data;

  // The RAM is read at the next-cycle head pointer so the head record is
  // already registered when a pop arrives, including back-to-back pops.
  trig_record_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (TRIG_REC_W)
  ) u_ram (
    .clk     (clk_adc),
    .nrst    (nrst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (wr_rec),
    .rd_addr (rd_ptr_d[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  // Next-state logic for pointers, flags, word select, counters and output.
  always_comb begin
    pop      = rd_en && !empty_q && !clear;
    pop_last = pop && (wsel_q == WSEL_W1);
    // When full, a slot freed by a last-word pop this cycle can take the write.
    wr_en    = trig_valid && !clear && (!full_q || pop_last);

    wr_rec           = '0;
    wr_rec.mask      = trig_mask;
    wr_rec.timestamp = trig_time;
`ifdef TRIGREC_SEQ_EN
    wr_rec.seq       = seq_q;
    wr_rec.drop      = drop_q[7:0];
`endif

    // A write landing on the slot being fetched is not visible in the RAM
    // read register yet; forward it for one cycle.
    head_rec = byp_q ? byp_rec_q : trig_record_t'(ram_rd_data);

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wsel_d   = WSEL_FIRST;
      drop_d   = 16'h0000;
    end else begin
      wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_last ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      if (pop) begin
        case (wsel_q)
          WSEL_HDR: wsel_d = WSEL_W0;
          WSEL_W0:  wsel_d = WSEL_W1;
          WSEL_W1:  wsel_d = WSEL_FIRST;
          default:  wsel_d = WSEL_FIRST;
        endcase
      end else begin
        wsel_d = wsel_q;
      end
      if (trig_valid && !wr_en && (drop_q != 16'hFFFF)) begin
        drop_d = drop_q + 16'd1;
      end else begin
        drop_d = drop_q;
      end
    end

`ifdef TRIGREC_SEQ_EN
    if (clear) begin
      seq_d = 8'h00;
    end else if (wr_en) begin
      seq_d = seq_q + 8'd1;
    end else begin
      seq_d = seq_q;
    end
`endif

    level_d = wr_ptr_d - rd_ptr_d;
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
              (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);

    byp_d     = wr_en && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    byp_rec_d = wr_rec;

    rd_valid_d = pop;
    if (pop) begin
      rd_data_d = rec_word(head_rec, wsel_q);
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      wsel_q     <= WSEL_FIRST;
      drop_q     <= 16'h0000;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0000_0000;
      byp_q      <= 1'b0;
      byp_rec_q  <= '0;
`ifdef TRIGREC_SEQ_EN
      seq_q      <= 8'h00;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      wsel_q     <= wsel_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      byp_q      <= byp_d;
      byp_rec_q  <= byp_rec_d;
`ifdef TRIGREC_SEQ_EN
      seq_q      <= seq_d;
`endif
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign level      = level_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trig_record_fifo.sv
// tb_trig_record_fifo: directed self-checking bench for trig_record_fifo
// (DEPTH=16). Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same point, so they reflect the cycle just completed.
module tb_trig_record_fifo;

`ifdef TRIGREC_SEQ_EN
  localparam int WPR = 3;
`else
  localparam int WPR = 2;
`endif

  logic        clk_adc = 1'b0;
  logic        nrst = 1'b0;
  logic        clear = 1'b0;
  logic        trig_valid = 1'b0;
  logic [7:0]  trig_mask = 8'h00;
  logic [55:0] trig_time = 56'h0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid, empty, full;
  logic [4:0]  level;
  logic [15:0] drop_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0]  m;
    logic [55:0] t;
    logic [7:0]  s;
    logic [7:0]  d;
  } exp_rec_t;

  exp_rec_t    sb[$];
  logic [7:0]  exp_seq = 8'h00;
  logic [15:0] exp_drop = 16'h0000;

  trig_record_fifo dut (
    .clk_adc    (clk_adc),
    .nrst       (nrst),
    .clear      (clear),
    .trig_valid (trig_valid),
    .trig_mask  (trig_mask),
    .trig_time  (trig_time),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .drop_count (drop_count)
  );

  always #5 clk_adc = ~clk_adc;

  function automatic logic [7:0] mk_mask(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  function automatic logic [55:0] mk_time(input int i);
    return {24'(i * 7 + 3), 32'(i) ^ 32'hDEAD_BEEF};
  endfunction

  // Expected readout word k of a record.
  function automatic logic [31:0] exp_word(input exp_rec_t r, input int k);
`ifdef TRIGREC_SEQ_EN
    if (k == 0) return {16'hA55A, r.d, r.s};
    else if (k == 1) return {r.m, r.t[55:32]};
    else return r.t[31:0];
`else
    if (k == 0) return {r.m, r.t[55:32]};
    else return r.t[31:0];
`endif
  endfunction

  task automatic step();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic do_write(input logic [7:0] m, input logic [55:0] t);
    trig_mask = m; trig_time = t; trig_valid = 1'b1;
    step();
    trig_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] m, input logic [55:0] t);
    sb.push_back('{m: m, t: t, s: exp_seq, d: exp_drop[7:0]});
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic wr_accept(input int i);
    do_write(mk_mask(i), mk_time(i));
    push_exp(mk_mask(i), mk_time(i));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    sb.delete();
    exp_seq = 8'h00;
    exp_drop = 16'h0000;
  endtask

  // Pops WPR consecutive words with rd_en held high.
  task automatic pop_record(output logic [2:0][31:0] got, output logic [2:0] gv);
    got = '0; gv = '0;
    rd_en = 1'b1;
    for (int k = 0; k < WPR; k++) begin
      step();
      got[k] = rd_data; gv[k] = rd_valid;
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk_adc);
    #1;
    vectors++;
    if (rd_data !== 32'h0 || rd_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
        level !== 5'd0 || drop_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset: data=%h valid=%b empty=%b full=%b level=%0d drop=%0d, need 0/0/1/0/0/0",
               rd_data, rd_valid, empty, full, level, drop_count);
    end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [2:0][31:0] got; logic [2:0] gv;
    do_write(8'h01, 56'h00_1234_5678_9ABC);
    push_exp(8'h01, 56'h00_1234_5678_9ABC);
    vectors++;
    if (empty !== 1'b0 || level !== 5'd1) begin
      miscompares++;
      $display("FAIL single_visible: empty=%b level=%0d, need 0/1", empty, level);
    end
    pop_record(got, gv);
    void'(sb.pop_front());
    vectors++;
    if (gv[WPR-1:WPR-2] !== 2'b11 || got[WPR-2] !== 32'h0100_1234 || got[WPR-1] !== 32'h5678_9ABC) begin
      miscompares++;
      $display("FAIL single_words: got %h %h valid %b, need 01001234 56789abc",
               got[WPR-2], got[WPR-1], gv);
    end
`ifdef TRIGREC_SEQ_EN
    vectors++;
    if (gv[0] !== 1'b1 || got[0] !== 32'hA55A_0000) begin
      miscompares++;
      $display("FAIL single_hdr: got %h, need a55a0000", got[0]);
    end
`endif
    vectors++;
    if (empty !== 1'b1 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL single_empty: empty=%b level=%0d, need 1/0", empty, level);
    end
  endtask

  task automatic test_full_drop();
    logic [2:0][31:0] got; logic [2:0] gv; exp_rec_t r;
    for (int i = 0; i < 16; i++) wr_accept(i);
    vectors++;
    if (full !== 1'b1 || level !== 5'd16 || drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL fill16: full=%b level=%0d drop=%0d, need 1/16/0", full, level, drop_count);
    end
    for (int i = 0; i < 3; i++) begin
      do_write(mk_mask(50 + i), mk_time(50 + i));
      exp_drop++;
    end
    vectors++;
    if (drop_count !== 16'd3 || level !== 5'd16 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: drop=%0d level=%0d full=%b, need 3/16/1", drop_count, level, full);
    end
    for (int i = 0; i < 16; i++) begin
      pop_record(got, gv);
      r = sb.pop_front();
      for (int k = 0; k < WPR; k++) begin
        vectors++;
        if (gv[k] !== 1'b1 || got[k] !== exp_word(r, k)) begin
          miscompares++;
          $display("FAIL drain16 rec %0d word %0d: got %h valid %b, need %h", i, k, got[k], gv[k], exp_word(r, k));
        end
      end
    end
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL drain16_empty: empty=%b full=%b, need 1/0", empty, full);
    end
    do_clear();
    vectors++;
    if (drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL clear_drop: drop=%0d, need 0", drop_count);
    end
  endtask

  task automatic test_simul();
    logic [2:0][31:0] got; logic [2:0] gv; exp_rec_t r;
    for (int i = 0; i < 16; i++) wr_accept(100 + i);
    rd_en = 1'b1;
    for (int k = 0; k < WPR - 1; k++) begin
      step();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== exp_word(sb[0], k)) begin
        miscompares++;
        $display("FAIL simul_head word %0d: got %h, need %h", k, rd_data, exp_word(sb[0], k));
      end
    end
    trig_mask = mk_mask(200); trig_time = mk_time(200); trig_valid = 1'b1;
    step();
    rd_en = 1'b0; trig_valid = 1'b0;
    r = sb.pop_front();
    push_exp(mk_mask(200), mk_time(200));
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_word(r, WPR - 1)) begin
      miscompares++;
      $display("FAIL simul_last: got %h valid %b, need %h", rd_data, rd_valid, exp_word(r, WPR - 1));
    end
    vectors++;
    if (level !== 5'd16 || full !== 1'b1 || drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL simul_flags: level=%0d full=%b drop=%0d, need 16/1/0", level, full, drop_count);
    end
    for (int i = 0; i < 16; i++) begin
      pop_record(got, gv);
      r = sb.pop_front();
      for (int k = 0; k < WPR; k++) begin
        vectors++;
        if (gv[k] !== 1'b1 || got[k] !== exp_word(r, k)) begin
          miscompares++;
          $display("FAIL simul_drain rec %0d word %0d: got %h, need %h", i, k, got[k], exp_word(r, k));
        end
      end
    end
  endtask

  task automatic test_empty_read_and_wrap();
    logic [2:0][31:0] got; logic [2:0] gv; exp_rec_t r;
    wr_accept(7);
    pop_record(got, gv);
    r = sb.pop_front();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    vectors++;
    if (rd_valid !== 1'b0 || rd_data !== exp_word(r, WPR - 1) || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_read: valid=%b data=%h empty=%b, need 0/%h/1", rd_valid, rd_data, empty, exp_word(r, WPR - 1));
    end
    for (int i = 0; i < 10000; i++) begin
      wr_accept(1000 + i);
      pop_record(got, gv);
      r = sb.pop_front();
      vectors++;
      if (gv[WPR-1:0] !== {WPR{1'b1}} || got[WPR-1] !== exp_word(r, WPR - 1) ||
          got[WPR-2] !== exp_word(r, WPR - 2) || got[0] !== exp_word(r, 0)) begin
        miscompares++;
        $display("FAIL wrap rec %0d: got %h %h %h valid %b", i, got[0], got[1], got[2], gv);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_rec_t r;
    for (int i = 0; i < 4; i++) wr_accept(300 + i);
    rd_en = 1'b1;
    for (int n = 0; n < 4 * WPR; n++) begin
      step();
      if (n % WPR == 0) r = sb.pop_front();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== exp_word(r, n % WPR)) begin
        miscompares++;
        $display("FAIL b2b cycle %0d: got %h valid %b, need %h", n, rd_data, rd_valid, exp_word(r, n % WPR));
      end
    end
    rd_en = 1'b0;
    step();
    vectors++;
    if (rd_valid !== 1'b0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_end: valid=%b empty=%b, need 0/1", rd_valid, empty);
    end
  endtask

  task automatic test_clear_mid();
    logic [2:0][31:0] got; logic [2:0] gv; exp_rec_t r;
    wr_accept(400);
    wr_accept(401);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    vectors++;
    if (rd_data !== exp_word(sb[0], 0)) begin
      miscompares++;
      $display("FAIL clear_mid_w0: got %h, need %h", rd_data, exp_word(sb[0], 0));
    end
    do_clear();
    vectors++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_mid_flags: level=%0d empty=%b full=%b, need 0/1/0", level, empty, full);
    end
    wr_accept(402);
    pop_record(got, gv);
    r = sb.pop_front();
    for (int k = 0; k < WPR; k++) begin
      vectors++;
      if (gv[k] !== 1'b1 || got[k] !== exp_word(r, k)) begin
        miscompares++;
        $display("FAIL clear_mid_next word %0d: got %h, need %h", k, got[k], exp_word(r, k));
      end
    end
  endtask

`ifdef TRIGREC_SEQ_EN
  task automatic test_seq();
    logic [2:0][31:0] got; logic [2:0] gv;
    do_clear();
    for (int i = 0; i < 257; i++) begin
      wr_accept(500 + i);
      pop_record(got, gv);
      void'(sb.pop_front());
      vectors++;
      if (gv[0] !== 1'b1 || got[0] !== {16'hA55A, 8'h00, 8'(i)}) begin
        miscompares++;
        $display("FAIL seq hdr %0d: got %h, need %h", i, got[0], {16'hA55A, 8'h00, 8'(i)});
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [2:0][31:0] got; logic [2:0] gv; exp_rec_t r;
    wr_accept(600);
    wr_accept(601);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    vectors++;
    if (rd_data !== 32'h0 || rd_valid !== 1'b0 || empty !== 1'b1 || level !== 5'd0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: data=%h valid=%b empty=%b level=%0d, need 0/0/1/0", rd_data, rd_valid, empty, level);
    end
    step();
    nrst = 1'b1;
    sb.delete(); exp_seq = 8'h00; exp_drop = 16'h0000;
    step();
    wr_accept(602);
    pop_record(got, gv);
    r = sb.pop_front();
    for (int k = 0; k < WPR; k++) begin
      vectors++;
      if (gv[k] !== 1'b1 || got[k] !== exp_word(r, k)) begin
        miscompares++;
        $display("FAIL reset_mid_next word %0d: got %h, need %h", k, got[k], exp_word(r, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_drop();
    test_simul();
    test_empty_read_and_wrap();
    test_back_to_back();
    test_clear_mid();
`ifdef TRIGREC_SEQ_EN
    test_seq();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
